i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- I2S master transmitter; the transmit-side companion to the team's I2S master receiver.
- Generates sck and ws from clk using the same prescaler, 32-bit-slot and ws conventions as the receiver, so both can share one bus.
- Software pushes right-aligned samples into an internal FIFO; the block serializes them MSB-first on sdo.
- Supports standard I2S and left-justified framing, and mono-left, mono-right or stereo channel selection.

Parameters:
- AW, 4, FIFO address width; depth DEPTH = 2**AW.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- en  in  1  enable; low forces idle
- sck_prescaler  in  8  sck half-period = sck_prescaler+1 clk cycles
- sample_size  in  5  bits per sample; 0 means 32
- left_justified  in  1  1 = MSB aligned with ws edge; 0 = standard I2S (MSB one sck later)
- channels  in  2  10 = left only, 01 = right only, 11 = stereo
- fifo_wr  in  1  push strobe, one word per cycle high
- fifo_wdata  in  32  sample, right-aligned in bits [N-1:0]
- fifo_level_threshold  in  AW+1  threshold for fifo_level_below
- ovf_clr  in  1  clears ovf
- unf_clr  in  1  clears unf
- sck  out  1  serial clock
- ws  out  1  word select; 0 = left, 1 = right
- sdo  out  1  serial data
- fifo_full  out  1  level == DEPTH
- fifo_empty  out  1  level == 0
- fifo_level  out  AW+1  occupancy, 0..DEPTH
- fifo_level_below  out  1  fifo_level < fifo_level_threshold (refill request)
- ovf  out  1  sticky: push while full
- unf  out  1  sticky: pop needed while empty

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: sck=0, ws=1, sdo=0, ovf=0, unf=0, fifo_level=0, fifo_empty=1, fifo_full=0, prescaler=0, bit_ctr=0, shift register=0.
- en=0 (synchronous): sck=0, ws=1, sdo=0, prescaler and bit_ctr cleared. FIFO contents and flags are kept. The same applies to en dropping mid-frame; the next en=1 restarts from the reset framing state.
- Prescaler: while en=1, counts down and reloads sck_prescaler at 0. At each prescaler==0 cycle, sck toggles.
- Rise event: sck 0->1. No output changes.
- Fall event: sck 1->0.
  - If bit_ctr==31: bit_ctr<=0 and ws toggles.
  - Otherwise: bit_ctr<=bit_ctr+1.
  - Each slot is 32 sck; each frame is 64 sck.
- sdo and ws change only on fall events, so the receiver samples on rising sck.
- Load point is a fall event:
  - left_justified=1: the ws-toggle edge.
  - left_justified=0: the edge where bit_ctr becomes 1.
  - The slot channel is the post-toggle ws value.
- At the load point:
  - If the slot's channel is enabled (ws=0 and channels[1], or ws=1 and channels[0]): pop one FIFO word and load shreg = word << (32-N), where N = sample_size (32 if 0). sdo = shreg[31] from the same edge.
  - If the channel is disabled: load 0 and do not pop.
  - If the channel is enabled and the FIFO is empty: load 0, set unf, do not pop.
- Other fall events: shreg <<= 1, zero fill. Bits beyond N are therefore 0.
  - In I2S mode, slot bit 31 falls after the next ws edge. It is the LSB only when N=32.
- First frame: after en rises, ws stays 1 for 32 sck with sdo=0 and no pop. In I2S mode the first possible pop is at the load point after the first ws 1->0. Stereo order is left then right.
- FIFO:
  - Push is accepted iff fifo_full==0 at that cycle; otherwise the word is dropped and ovf is set.
  - A pop in the same cycle does not free space for that cycle's push.
  - A pop on an empty FIFO with a simultaneous push: unf is set, and the pushed word is stored.
  - Pointers wrap modulo DEPTH. The level updates one cycle after the strobe.
- Sticky flags: set has priority over clr in the same cycle.

Decomposition:
- Shared package, alongside the receiver:
  - WS_LEFT=0 and WS_RIGHT=1.
  - CH_LEFT=2'b10, CH_RIGHT=2'b01, CH_STEREO=2'b11.
  - SLOT_BITS=32.
- One sub-module, i2s_tx_fifo (DW=32, AW): synchronous FIFO with an AW+1-bit level and show-ahead read data.
- Clock generation, framing and the shifter stay in i2s_tx.

Test Plan:
1. Reset with en=0 -> sck=0, ws=1, sdo=0, fifo_empty=1, fifo_level=0, ovf=unf=0; the outputs hold for 100 clk.
2. Prescaler=1, left_justified=1, channels=10, sample_size=16, push 0x0000A5A5, en=1 ->
   - sck period is 4 clk.
   - After the first ws 1->0, sdo on the rising edges reads 1010010110100101 then 16 zeros.
   - The right slot is all zero, and fifo_level goes 1->0.
3. Same as 2 with left_justified=0 -> the MSB appears one sck after ws falls, and ws is low for exactly 32 sck.
4. Stereo, sample_size=0, push 0x80000001 then 0x7FFFFFFE ->
   - The left slot carries 0x80000001 MSB-first and the right slot carries 0x7FFFFFFE.
   - In I2S mode, the left LSB (1) appears on the first sck after ws rises.
5. Stereo with an empty FIFO -> sdo=0 and unf=1 at the first left load point; unf_clr pulse -> unf=0.
6. Push 17 words with DEPTH=16 -> fifo_full=1, fifo_level=16, ovf=1, and the 17th word never appears on sdo. With threshold=4, fifo_level_below=1 once the level drops to 3. Dropping en mid-slot -> idle values on the next clk and the FIFO level is unchanged.

Source files
------------

// File: rtl/i2s_tx_pkg.sv
// Shared I2S definitions: word-select encoding, channel-select codes and slot geometry.
// The receiver and transmitter both import this package so that they agree on one bus.
package i2s_tx_pkg;

  typedef enum logic {
    WS_LEFT  = 1'b0,
    WS_RIGHT = 1'b1
  } ws_e;

  localparam logic [1:0] CH_LEFT   = 2'b10;
  localparam logic [1:0] CH_RIGHT  = 2'b01;
  localparam logic [1:0] CH_STEREO = 2'b11;

  localparam int unsigned SLOT_BITS = 32;

  // Left shift that moves a right-aligned sample of sample_size bits up to the MSB (0 means 32 bits).
  function automatic logic [5:0] size_shift(input logic [4:0] sample_size);
    logic [5:0] n;
    n = (sample_size == '0) ? 6'(SLOT_BITS) : {1'b0, sample_size};
    return 6'(SLOT_BITS) - n;
  endfunction

  function automatic logic slot_enabled(input ws_e ws, input logic [1:0] channels);
    return (ws == WS_LEFT) ? |(channels & CH_LEFT) : |(channels & CH_RIGHT);
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous FIFO with show-ahead read data and an occupancy count running from 0 to DEPTH.
// A write while full and a read while empty are both ignored.
module i2s_tx_fifo #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam int unsigned DEPTH = 2**AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level_q;
  logic          push_ok, pop_ok;

  always_comb begin
    full    = (level_q == (AW+1)'(DEPTH));
    empty   = (level_q == '0);
    // Acceptance depends only on the current flags, so a same-cycle pop never makes room for a push.
    push_ok = wr && !full;
    pop_ok  = rd && !empty;
    rdata   = mem[rptr];
    level   = level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: derives sck/ws from clk and shifts FIFO samples out MSB-first on sdo.
// sdo and ws change only on falling sck so that the receiver samples them on rising sck.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [7:0]    sck_prescaler,
  input  logic [4:0]    sample_size,
  input  logic          left_justified,
  input  logic [1:0]    channels,
  input  logic          fifo_wr,
  input  logic [31:0]   fifo_wdata,
  input  logic [AW:0]   fifo_level_threshold,
  input  logic          ovf_clr,
  input  logic          unf_clr,
  output logic          sck,
  output logic          ws,
  output logic          sdo,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   fifo_level,
  output logic          fifo_level_below,
  output logic          ovf,
  output logic          unf
);

  logic [7:0]  presc;
  logic        sck_q;
  ws_e         ws_q, ws_nx;
  logic [4:0]  bit_ctr;
  logic [31:0] shreg;
  logic        started;
  logic        ovf_q, unf_q;

  logic        tick, fall, last_bit, load, chan_en, pop, unf_set, ovf_set;
  logic [31:0] rdata;

  i2s_tx_fifo #(
    .DW (SLOT_BITS),
    .AW (AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (fifo_wr),
    .wdata (fifo_wdata),
    .rd    (pop),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    tick     = en && (presc == '0);
    fall     = tick && sck_q;
    last_bit = (bit_ctr == 5'd31);
    ws_nx    = ws_q;
    if (last_bit) ws_nx = (ws_q == WS_LEFT) ? WS_RIGHT : WS_LEFT;
    // 'started' masks the bit_ctr==0 fall of the opening all-ones ws slot in I2S mode.
    load = 1'b0;
    if (fall) load = left_justified ? last_bit : (started && (bit_ctr == '0));
    chan_en = slot_enabled(ws_nx, channels);
    pop     = load && chan_en && !fifo_empty;
    unf_set = load && chan_en && fifo_empty;
    ovf_set = fifo_wr && fifo_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= WS_RIGHT;
      bit_ctr <= '0;
      shreg   <= '0;
      started <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
      unf_q <= unf_set | (unf_q & ~unf_clr);
      if (!en) begin
        presc   <= '0;
        sck_q   <= 1'b0;
        ws_q    <= WS_RIGHT;
        bit_ctr <= '0;
        shreg   <= '0;
        started <= 1'b0;
      end else if (tick) begin
        presc <= sck_prescaler;
        sck_q <= ~sck_q;
        if (sck_q) begin
          bit_ctr <= bit_ctr + 5'd1;
          ws_q    <= ws_nx;
          if (last_bit) started <= 1'b1;
          if (load) shreg <= pop ? (rdata << size_shift(sample_size)) : '0;
          else      shreg <= {shreg[30:0], 1'b0};
        end
      end else begin
        presc <= presc - 8'd1;
      end
    end
  end

  always_comb begin
    sck              = sck_q;
    ws               = ws_q;
    sdo              = shreg[31];
    ovf              = ovf_q;
    unf              = unf_q;
    fifo_level_below = (fifo_level < fifo_level_threshold);
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: framing, alignment modes, channel selection, FIFO limits and flags.
// Serial data is captured on every rising sck, as an I2S receiver would see it.
module tb_i2s_tx;
  import i2s_tx_pkg::*;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [7:0]    sck_prescaler;
  logic [4:0]    sample_size;
  logic          left_justified;
  logic [1:0]    channels;
  logic          fifo_wr;
  logic [31:0]   fifo_wdata;
  logic [AW:0]   fifo_level_threshold;
  logic          ovf_clr, unf_clr;
  logic          sck, ws, sdo, fifo_full, fifo_empty, fifo_level_below, ovf, unf;
  logic [AW:0]   fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_tx #(.AW(AW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .en                   (en),
    .sck_prescaler        (sck_prescaler),
    .sample_size          (sample_size),
    .left_justified       (left_justified),
    .channels             (channels),
    .fifo_wr              (fifo_wr),
    .fifo_wdata           (fifo_wdata),
    .fifo_level_threshold (fifo_level_threshold),
    .ovf_clr              (ovf_clr),
    .unf_clr              (unf_clr),
    .sck                  (sck),
    .ws                   (ws),
    .sdo                  (sdo),
    .fifo_full            (fifo_full),
    .fifo_empty           (fifo_empty),
    .fifo_level           (fifo_level),
    .fifo_level_below     (fifo_level_below),
    .ovf                  (ovf),
    .unf                  (unf)
  );

  // Waits for the next rising sck (seen at a falling clk) and returns sdo/ws plus clk cycles waited.
  task automatic next_rise(output logic s, output logic w, output int cyc);
    logic prev;
    prev = sck;
    cyc  = 0;
    s    = 1'b0;
    w    = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cyc++;
      if (sck && !prev) begin
        s = sdo;
        w = ws;
        return;
      end
      prev = sck;
    end
    checks++;
    errors++;
    $display("FAIL sck_timeout: no rising sck within 2000 clk, required one");
  endtask

  // Consumes the ws=1 opening slot; returns the first ws=0 rise and the ws=1 rise count.
  task automatic skip_first_frame(output logic s, output logic w, output int n_hi, output int per);
    int cyc;
    n_hi = 0;
    per  = 0;
    next_rise(s, w, cyc);
    while (w && n_hi < 40) begin
      n_hi++;
      next_rise(s, w, cyc);
      if (n_hi == 1) per = cyc;
    end
  endtask

  // Shifts n more rising-sck sdo bits into seed; reports whether ws was high/low on any of them.
  task automatic shift_in(input int n, input logic [31:0] seed, output logic [31:0] bits,
                          output logic any_hi, output logic any_lo);
    logic s, w;
    int cyc;
    bits   = seed;
    any_hi = 1'b0;
    any_lo = 1'b0;
    for (int i = 0; i < n; i++) begin
      next_rise(s, w, cyc);
      bits = {bits[30:0], s};
      if (w) any_hi = 1'b1;
      else   any_lo = 1'b1;
    end
  endtask

  task automatic push(input logic [31:0] d);
    fifo_wr    = 1'b1;
    fifo_wdata = d;
    @(negedge clk);
    fifo_wr    = 1'b0;
  endtask

  task automatic quiesce();
    @(negedge clk);
    en      = 1'b0;
    fifo_wr = 1'b0;
    ovf_clr = 1'b1;
    unf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    unf_clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] exp_v, act_v;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    act_v = {sck, ws, sdo, fifo_empty, fifo_full, ovf, unf, fifo_level};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL reset_in: got %h required %h", act_v, exp_v);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      act_v = {sck, ws, sdo, fifo_empty, fifo_full, ovf, unf, fifo_level};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h required %h", i, act_v, exp_v);
      end
    end
    checks++;
    if (fifo_level_below !== 1'b1) begin
      errors++;
      $display("FAIL reset_below: got %b required 1", fifo_level_below);
    end
  endtask

  task automatic test_left_justified_mono();
    logic s, w, hi, lo;
    int n_hi, per;
    logic [31:0] bits;
    quiesce();
    sck_prescaler = 8'd1; left_justified = 1'b1; channels = CH_LEFT; sample_size = 5'd16;
    push(32'h0000_A5A5);
    checks++;
    if (fifo_level !== 5'd1) begin
      errors++;
      $display("FAIL lj_level_pre: got %0d required 1", fifo_level);
    end
    en = 1'b1;
    skip_first_frame(s, w, n_hi, per);
    checks++;
    if (per !== 4) begin
      errors++;
      $display("FAIL lj_sck_period: got %0d clk required 4", per);
    end
    checks++;
    if (n_hi !== 32) begin
      errors++;
      $display("FAIL lj_first_slot: got %0d ws-high sck required 32", n_hi);
    end
    shift_in(31, {31'b0, s}, bits, hi, lo);
    checks++;
    if (bits !== 32'hA5A5_0000 || hi) begin
      errors++;
      $display("FAIL lj_left_slot: got %h ws_high_seen %b required a5a50000 with ws low", bits, hi);
    end
    checks++;
    if (fifo_level !== 5'd0) begin
      errors++;
      $display("FAIL lj_level_post: got %0d required 0", fifo_level);
    end
    shift_in(32, 32'h0, bits, hi, lo);
    checks++;
    if (bits !== 32'h0 || lo) begin
      errors++;
      $display("FAIL lj_right_slot: got %h ws_low_seen %b required 00000000 with ws high", bits, lo);
    end
    en = 1'b0;
  endtask

  task automatic test_i2s_mono();
    logic s, w, hi, lo;
    int n_hi, per, cyc;
    logic [31:0] bits;
    quiesce();
    sck_prescaler = 8'd1; left_justified = 1'b0; channels = CH_LEFT; sample_size = 5'd16;
    push(32'h0000_A5A5);
    en = 1'b1;
    skip_first_frame(s, w, n_hi, per);
    checks++;
    if (n_hi !== 32) begin
      errors++;
      $display("FAIL i2s_first_slot: got %0d ws-high sck required 32", n_hi);
    end
    checks++;
    if (s !== 1'b0) begin
      errors++;
      $display("FAIL i2s_msb_delay: got sdo %b on first ws-low sck required 0", s);
    end
    shift_in(31, 32'h0, bits, hi, lo);
    next_rise(s, w, cyc);
    bits = {bits[30:0], s};
    checks++;
    if (hi || w !== 1'b1) begin
      errors++;
      $display("FAIL i2s_ws_low_len: got ws %b on sck 33 required ws low for exactly 32 sck", w);
    end
    checks++;
    if (bits !== 32'hA5A5_0000) begin
      errors++;
      $display("FAIL i2s_left_slot: got %h required a5a50000", bits);
    end
    shift_in(31, 32'h0, bits, hi, lo);
    checks++;
    if (bits !== 32'h0) begin
      errors++;
      $display("FAIL i2s_right_slot: got %h required 00000000", bits);
    end
    en = 1'b0;
  endtask

  task automatic test_stereo();
    logic s, w, hi, lo;
    int n_hi, per, cyc;
    logic [31:0] bits;
    quiesce();
    sck_prescaler = 8'd1; left_justified = 1'b0; channels = CH_STEREO; sample_size = 5'd0;
    push(32'h8000_0001);
    push(32'h7FFF_FFFE);
    en = 1'b1;
    skip_first_frame(s, w, n_hi, per);
    shift_in(31, 32'h0, bits, hi, lo);
    next_rise(s, w, cyc);
    bits = {bits[30:0], s};
    checks++;
    if (s !== 1'b1 || w !== 1'b1) begin
      errors++;
      $display("FAIL st_left_lsb: got sdo %b ws %b required sdo 1 ws 1", s, w);
    end
    checks++;
    if (bits !== 32'h8000_0001) begin
      errors++;
      $display("FAIL st_left_word: got %h required 80000001", bits);
    end
    shift_in(31, 32'h0, bits, hi, lo);
    next_rise(s, w, cyc);
    bits = {bits[30:0], s};
    checks++;
    if (bits !== 32'h7FFF_FFFE || w !== 1'b0) begin
      errors++;
      $display("FAIL st_right_word: got %h ws %b required 7ffffffe ws 0", bits, w);
    end
    checks++;
    if (fifo_level !== 5'd0) begin
      errors++;
      $display("FAIL st_level: got %0d required 0", fifo_level);
    end
    en = 1'b0;
  endtask

  task automatic test_underflow();
    logic s, w, early;
    int cyc, n;
    quiesce();
    sck_prescaler = 8'd1; left_justified = 1'b1; channels = CH_STEREO; sample_size = 5'd16;
    en    = 1'b1;
    early = 1'b0;
    n     = 0;
    next_rise(s, w, cyc);
    while (w && n < 40) begin
      if (unf) early = 1'b1;
      n++;
      next_rise(s, w, cyc);
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL unf_early: got unf during first frame required 0");
    end
    checks++;
    if (s !== 1'b0 || unf !== 1'b1) begin
      errors++;
      $display("FAIL unf_set: got sdo %b unf %b required sdo 0 unf 1", s, unf);
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (unf !== 1'b1) begin
      errors++;
      $display("FAIL unf_sticky: got %b required 1", unf);
    end
    unf_clr = 1'b1;
    @(negedge clk);
    unf_clr = 1'b0;
    checks++;
    if (unf !== 1'b0) begin
      errors++;
      $display("FAIL unf_clear: got %b required 0", unf);
    end
  endtask

  task automatic test_fifo_limits();
    logic s, w, hi, lo, exp_below;
    int n_hi, per, cyc;
    logic [31:0] bits, exp_word;
    logic [AW:0] exp_level;
    quiesce();
    sck_prescaler = 8'd1; left_justified = 1'b1; channels = CH_STEREO; sample_size = 5'd0;
    fifo_level_threshold = 5'd4;
    fifo_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      fifo_wdata = 32'hC0DE_0000 | i;
      @(negedge clk);
    end
    fifo_wr = 1'b0;
    checks++;
    if ({fifo_full, fifo_level, ovf, fifo_level_below} !== {1'b1, 5'd16, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fifo_fill16: got full %b level %0d ovf %b below %b required 1 16 0 0",
               fifo_full, fifo_level, ovf, fifo_level_below);
    end
    push(32'hDEAD_BEEF);
    checks++;
    if ({fifo_full, fifo_level, ovf} !== {1'b1, 5'd16, 1'b1}) begin
      errors++;
      $display("FAIL fifo_ovf: got full %b level %0d ovf %b required 1 16 1", fifo_full, fifo_level, ovf);
    end
    en = 1'b1;
    skip_first_frame(s, w, n_hi, per);
    for (int k = 0; k < 14; k++) begin
      shift_in(31, {31'b0, s}, bits, hi, lo);
      exp_word  = 32'hC0DE_0000 | k;
      exp_level = 5'(15 - k);
      exp_below = (15 - k) < 4;
      checks++;
      if (bits !== exp_word) begin
        errors++;
        $display("FAIL drain_word %0d: got %h required %h", k, bits, exp_word);
      end
      checks++;
      if (fifo_level !== exp_level || fifo_level_below !== exp_below) begin
        errors++;
        $display("FAIL drain_level %0d: got level %0d below %b required %0d %b",
                 k, fifo_level, fifo_level_below, exp_level, exp_below);
      end
      next_rise(s, w, cyc);
    end
    shift_in(9, {31'b0, s}, bits, hi, lo);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({sck, ws, sdo, fifo_level} !== {1'b0, 1'b1, 1'b0, 5'd1}) begin
      errors++;
      $display("FAIL en_drop: got sck %b ws %b sdo %b level %0d required 0 1 0 1", sck, ws, sdo, fifo_level);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (fifo_level !== 5'd1) begin
      errors++;
      $display("FAIL en_drop_hold: got level %0d required 1", fifo_level);
    end
    en = 1'b1;
    skip_first_frame(s, w, n_hi, per);
    checks++;
    if (n_hi !== 32) begin
      errors++;
      $display("FAIL restart_frame: got %0d ws-high sck required 32", n_hi);
    end
    shift_in(31, {31'b0, s}, bits, hi, lo);
    checks++;
    if (bits !== 32'hC0DE_000F) begin
      errors++;
      $display("FAIL restart_word: got %h required c0de000f", bits);
    end
    shift_in(32, 32'h0, bits, hi, lo);
    checks++;
    if (bits !== 32'h0 || unf !== 1'b1 || fifo_level !== 5'd0) begin
      errors++;
      $display("FAIL dropped_word: got %h unf %b level %0d required 00000000 1 0", bits, unf, fifo_level);
    end
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sck_prescaler = 8'd0; sample_size = 5'd0; left_justified = 1'b1;
    channels = CH_STEREO; fifo_wr = 1'b0; fifo_wdata = '0; fifo_level_threshold = 5'd4;
    ovf_clr = 1'b0; unf_clr = 1'b0;
    test_reset();
    test_left_justified_mono();
    test_i2s_mono();
    test_stereo();
    test_underflow();
    test_fifo_limits();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
